alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_if.sv | 39 +++
 rtl/alu_sched.sv | 115 +++++++++++
 tb/tb_alu_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - request, shared-ALU and response signals of alu_sched
// master is the requester/ALU/consumer side, slave is the scheduler.
interface alu_sched_if #(
  parameter int BW = 16
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [BW-1:0] req_a0;
  logic [BW-1:0] req_b0;
  logic [BW-1:0] req_a1;
  logic [BW-1:0] req_b1;
  logic [3:0]    req_op0;
  logic [3:0]    req_op1;
  logic [BW-1:0] alu_a;
  logic [BW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic [BW-1:0] alu_out;
  logic [2:0]    alu_flags;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_out;
  logic [2:0]    rsp_flags;
  logic          rsp_id;
  logic          rsp_err;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
    output alu_out, alu_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_out, rsp_flags, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
    input  alu_out, alu_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_out, rsp_flags, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin scheduler sharing one combinational ALU between two requesters
// One operation in flight at a time: IDLE grants, EXEC samples the ALU, RESP holds the result.
module alu_sched #(
  parameter int BW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  alu_sched_if.slave    bus,
  output logic [CW-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  state_t        state_nx;
  logic          last_grant;
  logic [1:0]    grant;
  logic          win_id;
  logic          xfer;
  logic          rsp_hs;
  logic [3:0]    win_op;
  logic [BW-1:0] win_a;
  logic [BW-1:0] win_b;

  logic [BW-1:0] a_q;
  logic [BW-1:0] b_q;
  logic [3:0]    op_q;
  logic          id_q;
  logic [BW-1:0] out_q;
  logic [2:0]    flags_q;
  logic          err_q;
  logic [CW-1:0] done_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Grants are only offered in IDLE and never while reset is asserted.
  always_comb begin
    grant    = 2'b00;
    win_id   = 1'b0;
    state_nx = state;
    if (state == IDLE && !rst) begin
      case (bus.req_valid)
        2'b01: begin grant = 2'b01; win_id = 1'b0; end
        2'b10: begin grant = 2'b10; win_id = 1'b1; end
        2'b11: begin
          win_id = ~last_grant;
          grant  = last_grant ? 2'b01 : 2'b10;
        end
        default: begin grant = 2'b00; win_id = 1'b0; end
      endcase
    end
    xfer   = |grant;
    rsp_hs = (state == RESP) && bus.rsp_ready;
    win_op = win_id ? bus.req_op1 : bus.req_op0;
    win_a  = win_id ? bus.req_a1  : bus.req_a0;
    win_b  = win_id ? bus.req_b1  : bus.req_b0;
    case (state)
      IDLE:    if (xfer) state_nx = win_op[3] ? RESP : EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      out_q      <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= '0;
    end else begin
      if (xfer) begin
        last_grant <= win_id;
        id_q       <= win_id;
        // Illegal opcodes never reach the ALU, so its operand registers keep their old values.
        if (win_op[3]) begin
          out_q   <= '0;
          flags_q <= '0;
          err_q   <= 1'b1;
        end else begin
          a_q  <= win_a;
          b_q  <= win_b;
          op_q <= win_op;
        end
      end
      if (state == EXEC) begin
        out_q   <= bus.alu_out;
        flags_q <= bus.alu_flags;
        err_q   <= 1'b0;
      end
      if (rsp_hs) done_q <= done_q + 1'b1;
    end
  end

  assign bus.req_ready = grant;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_out   = out_q;
  assign bus.rsp_flags = flags_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_err   = err_q;
  assign ops_done      = done_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched
// A small ALU (add/sub/and/or/xor/pass) answers the scheduler's operand outputs.
module tb_alu_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ops_done;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] r;
  logic        ovf;

  alu_sched_if #(.BW(16)) bus ();

  alu_sched #(.BW(16), .CW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    r   = '0;
    ovf = 1'b0;
    case (bus.alu_op)
      4'd0: begin
        r   = bus.alu_a + bus.alu_b;
        ovf = (bus.alu_a[15] == bus.alu_b[15]) && (r[15] != bus.alu_a[15]);
      end
      4'd1: begin
        r   = bus.alu_a - bus.alu_b;
        ovf = (bus.alu_a[15] != bus.alu_b[15]) && (r[15] != bus.alu_a[15]);
      end
      4'd2:    r = bus.alu_a & bus.alu_b;
      4'd3:    r = bus.alu_a | bus.alu_b;
      4'd4:    r = bus.alu_a ^ bus.alu_b;
      default: r = bus.alu_a;
    endcase
    bus.alu_out   = r;
    bus.alu_flags = {ovf, r[15], (r == 16'd0)};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
    tick;
    tick;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (ops_done !== 4'd0) begin errors++; $display("FAIL reset_ops_done got %0d exp 0", ops_done); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 36'd0) begin errors++; $display("FAIL reset_alu got %h/%h/%h exp 0", bus.alu_a, bus.alu_b, bus.alu_op); end
    checks++; if ({bus.rsp_out, bus.rsp_flags, bus.rsp_id, bus.rsp_err} !== 21'd0) begin errors++; $display("FAIL reset_rsp_payload got %h %b %b %b exp 0", bus.rsp_out, bus.rsp_flags, bus.rsp_id, bus.rsp_err); end
    rst = 1'b0;
    bus.req_valid = 2'b00;
    #1;
  endtask

  task automatic test_single;
    bus.req_a0 = 16'd20; bus.req_b0 = 16'd5; bus.req_op0 = 4'd0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", bus.req_ready); end
    tick;
    bus.req_valid = 2'b00;
    checks++; if (bus.alu_a !== 16'd20 || bus.alu_b !== 16'd5) begin errors++; $display("FAIL single_alu_ops got %0d/%0d exp 20/5", bus.alu_a, bus.alu_b); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_valid got %b exp 0", bus.rsp_valid); end
    tick;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", bus.rsp_valid); end
    checks++; if ({bus.rsp_out, bus.rsp_flags, bus.rsp_id, bus.rsp_err} !== {16'd25, 3'b000, 1'b0, 1'b0}) begin errors++; $display("FAIL single_payload got %0d %b %b %b exp 25 000 0 0", bus.rsp_out, bus.rsp_flags, bus.rsp_id, bus.rsp_err); end
    tick;
    checks++; if (ops_done !== 4'd1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done got %0d valid %b exp 1 valid 0", ops_done, bus.rsp_valid); end
    // Signed overflow on add: 0x7fff + 1 -> 0x8000, flags {ovf,neg,zero} = 110.
    bus.req_a0 = 16'h7fff; bus.req_b0 = 16'd1; bus.req_op0 = 4'd0;
    bus.req_valid = 2'b01;
    tick;
    bus.req_valid = 2'b00;
    tick;
    checks++; if (bus.rsp_out !== 16'h8000 || bus.rsp_flags !== 3'b110) begin errors++; $display("FAIL ovf_payload got %h %b exp 8000 110", bus.rsp_out, bus.rsp_flags); end
    tick;
    checks++; if (ops_done !== 4'd2) begin errors++; $display("FAIL ovf_done got %0d exp 2", ops_done); end
  endtask

  task automatic test_contention;
    logic [1:0]  exp_grant;
    logic [15:0] exp_out;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.req_a0 = 16'd3;  bus.req_b0 = 16'd4; bus.req_op0 = 4'd0;
    bus.req_a1 = 16'd10; bus.req_b1 = 16'd2; bus.req_op1 = 4'd1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_grant = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_out   = (k % 2 == 1) ? 16'd8 : 16'd7;
      checks++; if (bus.req_ready !== exp_grant) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", k, bus.req_ready, exp_grant); end
      tick;
      tick;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_grant[1] || bus.rsp_out !== exp_out) begin errors++; $display("FAIL cont_rsp%0d got v%b id%b out%0d exp v1 id%b out%0d", k, bus.rsp_valid, bus.rsp_id, bus.rsp_out, exp_grant[1], exp_out); end
      tick;
    end
    bus.req_valid = 2'b00;
    checks++; if (ops_done !== 4'd4) begin errors++; $display("FAIL cont_done got %0d exp 4", ops_done); end
  endtask

  task automatic test_illegal;
    bus.req_a1 = 16'd55; bus.req_b1 = 16'd66; bus.req_op1 = 4'b1010;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL ill_grant got %b exp 10", bus.req_ready); end
    tick;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL ill_latency got %b exp 1", bus.rsp_valid); end
    checks++; if ({bus.rsp_out, bus.rsp_flags, bus.rsp_id, bus.rsp_err} !== {16'd0, 3'b000, 1'b1, 1'b1}) begin errors++; $display("FAIL ill_payload got %0d %b %b %b exp 0 000 1 1", bus.rsp_out, bus.rsp_flags, bus.rsp_id, bus.rsp_err); end
    checks++; if (bus.alu_a !== 16'd10 || bus.alu_b !== 16'd2 || bus.alu_op !== 4'd1) begin errors++; $display("FAIL ill_alu_hold got %0d/%0d/%0d exp 10/2/1", bus.alu_a, bus.alu_b, bus.alu_op); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL ill_no_grant got %b exp 00", bus.req_ready); end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick;
    checks++; if (ops_done !== 4'd5 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_done got %0d valid %b exp 5 valid 0", ops_done, bus.rsp_valid); end
  endtask

  task automatic test_backpressure;
    bus.req_a0 = 16'd100; bus.req_b0 = 16'd30; bus.req_op0 = 4'd1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    tick;
    bus.req_valid = 2'b11;
    tick;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_out !== 16'd70 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_flags !== 3'b000) begin errors++; $display("FAIL bp_hold%0d got v%b out%0d id%b err%b fl%b exp v1 out70 id0 err0 fl000", k, bus.rsp_valid, bus.rsp_out, bus.rsp_id, bus.rsp_err, bus.rsp_flags); end
      checks++; if (bus.req_ready !== 2'b00 || ops_done !== 4'd5) begin errors++; $display("FAIL bp_stall%0d got rdy%b done%0d exp rdy00 done5", k, bus.req_ready, ops_done); end
      tick;
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick;
    checks++; if (ops_done !== 4'd6) begin errors++; $display("FAIL bp_release got %0d exp 6", ops_done); end
    tick;
    checks++; if (ops_done !== 4'd6) begin errors++; $display("FAIL bp_single_inc got %0d exp 6", ops_done); end
  endtask

  task automatic test_mid_reset;
    bus.req_a0 = 16'd1; bus.req_b0 = 16'd2; bus.req_op0 = 4'd0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b01;
    tick;
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL mr_rst_ready got %b exp 00", bus.req_ready); end
    tick;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || ops_done !== 4'd0 || bus.alu_a !== 16'd0) begin errors++; $display("FAIL mr_abort got v%b done%0d a%0d exp v0 done0 a0", bus.rsp_valid, ops_done, bus.alu_a); end
    tick;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_no_rsp got %b exp 0", bus.rsp_valid); end
    bus.req_a1 = 16'd9; bus.req_b1 = 16'd4; bus.req_op1 = 4'd2;
    bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL mr_grant got %b exp 10", bus.req_ready); end
    tick;
    bus.req_valid = 2'b00;
    tick;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_out !== 16'd0 || bus.rsp_flags !== 3'b001 || bus.rsp_id !== 1'b1) begin errors++; $display("FAIL mr_rsp got v%b out%0d fl%b id%b exp v1 out0 fl001 id1", bus.rsp_valid, bus.rsp_out, bus.rsp_flags, bus.rsp_id); end
    tick;
    checks++; if (ops_done !== 4'd1) begin errors++; $display("FAIL mr_done got %0d exp 1", ops_done); end
  endtask

  task automatic test_wrap;
    logic bad;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.req_a0 = 16'h00f0; bus.req_b0 = 16'h0f0f; bus.req_op0 = 4'd4;
    bus.req_op1 = 4'd15;
    bus.rsp_ready = 1'b1;
    // Even ops are legal xor from requester 0, odd ops are illegal from requester 1.
    for (int k = 0; k < 16; k++) begin
      bus.req_valid = (k % 2 == 1) ? 2'b10 : 2'b01;
      tick;
      bus.req_valid = 2'b00;
      if (k % 2 == 0) tick;
      bad = (k % 2 == 1) ? (bus.rsp_err !== 1'b1 || bus.rsp_out !== 16'd0)
                         : (bus.rsp_err !== 1'b0 || bus.rsp_out !== 16'h0fff);
      checks++; if (bus.rsp_valid !== 1'b1 || bad) begin errors++; $display("FAIL wrap_rsp%0d got v%b err%b out%h", k, bus.rsp_valid, bus.rsp_err, bus.rsp_out); end
      tick;
      if (k == 14) begin
        checks++; if (ops_done !== 4'd15) begin errors++; $display("FAIL wrap_15 got %0d exp 15", ops_done); end
      end
    end
    checks++; if (ops_done !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", ops_done); end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
    bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;
    bus.rsp_ready = 1'b0;
    test_reset;
    test_single;
    test_contention;
    test_illegal;
    test_backpressure;
    test_mid_reset;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
